// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one synchronous RAM between a CPU port and a DMA port.
// Every beat is one ACC cycle (RAM strobe) followed by one RSP cycle (ack pulse).
module mem_port_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   // DMA port
   input  logic              dma_req,
   input  logic              dma_rw,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_last,
   output logic              dma_gnt,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   // RAM side
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
   localparam logic [3:0] CNT_MAX     = 4'd15;
   localparam logic       OWNER_CPU   = 1'b0;
   localparam logic       OWNER_DMA   = 1'b1;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [3:0]        beat_cnt_q, beat_cnt_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              last_q, last_d;

   logic              arb_window;
   logic              any_req;
   logic              start_beat;
   logic              burst_hold;
   logic              pick_dma;
   logic [3:0]        cnt_base;
   logic              in_acc;
   logic              in_rsp;

   // State and latched request fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_DMA;
         beat_cnt_q <= 4'd0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         last_q     <= last_d;
      end
   end

   // A non-zero beat count is what distinguishes a live burst from the reset default owner.
   always_comb begin
      arb_window = (state_q == ST_IDLE) || (state_q == ST_RSP);
      any_req    = cpu_req | dma_req;
      start_beat = arb_window && any_req;
      burst_hold = (owner_q == OWNER_DMA) && !last_q &&
                   (beat_cnt_q != 4'd0) && (beat_cnt_q < BURST_LIMIT);
      pick_dma   = 1'b0;
      if (dma_req && !cpu_req) begin
         pick_dma = 1'b1;
      end else if (dma_req && cpu_req) begin
         pick_dma = burst_hold || (owner_q == OWNER_CPU);
      end
   end

   // Next-state and next-field logic
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      last_d     = last_q;

      case (state_q)
         ST_IDLE: state_d = any_req ? ST_ACC : ST_IDLE;
         ST_ACC:  state_d = ST_RSP;
         ST_RSP:  state_d = any_req ? ST_ACC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A DMA beat finishing with dma_last ends the burst before the next grant is counted.
      cnt_base   = ((state_q == ST_RSP) && (owner_q == OWNER_DMA) && last_q) ? 4'd0 : beat_cnt_q;
      beat_cnt_d = cnt_base;

      if (start_beat) begin
         owner_d = pick_dma;
         if (pick_dma) begin
            rw_d       = dma_rw;
            addr_d     = dma_addr;
            wdata_d    = dma_wdata;
            last_d     = dma_last;
            beat_cnt_d = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 4'd1;
         end else begin
            rw_d       = cpu_rw;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
            last_d     = 1'b0;
            beat_cnt_d = 4'd0;
         end
      end
   end

   // Outputs decode only state and latched fields; rdata is a gated RAM passthrough.
   always_comb begin
      in_acc    = (state_q == ST_ACC);
      in_rsp    = (state_q == ST_RSP);

      cpu_gnt   = in_acc && (owner_q == OWNER_CPU);
      dma_gnt   = in_acc && (owner_q == OWNER_DMA);
      cpu_ack   = in_rsp && (owner_q == OWNER_CPU);
      dma_ack   = in_rsp && (owner_q == OWNER_DMA);

      cpu_rdata = (cpu_ack && !rw_q) ? mem_rdata : '0;
      dma_rdata = (dma_ack && !rw_q) ? mem_rdata : '0;

      mem_en    = in_acc;
      mem_rw    = in_acc && rw_q;
      mem_addr  = in_acc ? addr_q  : '0;
      mem_wdata = in_acc ? wdata_q : '0;

      busy      = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus hand-written burst,
// mid-access reset and dropped-request sequences against a small behavioural RAM.
module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_req, cpu_rw, cpu_gnt, cpu_ack;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       dma_req, dma_rw, dma_last, dma_gnt, dma_ack;
   logic [7:0] dma_addr, dma_wdata, dma_rdata;
   logic       mem_en, mem_rw, busy;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Behavioural synchronous RAM, preloaded on the first clock edge.
   logic [7:0] ram [0:255];
   logic       ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= (i == 16) ? 8'hA5 : 8'h00;
         ram_loaded <= 1'b1;
      end else if (mem_en) begin
         if (mem_rw) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct packed {
      logic       rst_n, cpu_req, cpu_rw;
      logic [7:0] cpu_addr, cpu_wdata;
      logic       dma_req, dma_rw;
      logic [7:0] dma_addr, dma_wdata;
      logic       dma_last;
   } vin_t;

   typedef struct packed {
      logic       cpu_gnt, cpu_ack;
      logic [7:0] cpu_rdata;
      logic       dma_gnt, dma_ack;
      logic [7:0] dma_rdata;
      logic       mem_en, mem_rw;
      logic [7:0] mem_addr, mem_wdata;
      logic       busy;
   } vout_t;

   typedef struct packed {
      vin_t  vin;
      vout_t vexp;
   } vec_t;

   vout_t act;
   assign act = {cpu_gnt, cpu_ack, cpu_rdata, dma_gnt, dma_ack, dma_rdata,
                 mem_en, mem_rw, mem_addr, mem_wdata, busy};

   int n_checks = 0;
   int n_pass   = 0;
   int excl_viol = 0;

   always @(negedge clk) begin
      if ((cpu_ack && dma_ack) || (cpu_gnt && dma_gnt)) excl_viol++;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   function automatic vin_t in_v(logic rst, logic creq, logic crw, logic [7:0] ca, logic [7:0] cwd,
                                 logic dreq, logic drw, logic [7:0] da, logic [7:0] dwd, logic dl);
      vin_t v;
      v = '{rst, creq, crw, ca, cwd, dreq, drw, da, dwd, dl};
      return v;
   endfunction

   function automatic vout_t o_idle();
      vout_t o;
      o = '0;
      return o;
   endfunction

   function automatic vout_t o_acc(logic is_dma, logic rw, logic [7:0] a, logic [7:0] wd);
      vout_t o;
      o = '0;
      o.cpu_gnt = !is_dma;
      o.dma_gnt = is_dma;
      o.mem_en = 1'b1;
      o.mem_rw = rw;
      o.mem_addr = a;
      o.mem_wdata = wd;
      o.busy = 1'b1;
      return o;
   endfunction

   function automatic vout_t o_rsp(logic is_dma, logic [7:0] rd);
      vout_t o;
      o = '0;
      o.cpu_ack = !is_dma;
      o.dma_ack = is_dma;
      o.cpu_rdata = is_dma ? 8'h00 : rd;
      o.dma_rdata = is_dma ? rd : 8'h00;
      o.busy = 1'b1;
      return o;
   endfunction

   task automatic apply_in(input vin_t v);
      rst_n = v.rst_n;   cpu_req = v.cpu_req; cpu_rw = v.cpu_rw;
      cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      dma_req = v.dma_req; dma_rw = v.dma_rw; dma_addr = v.dma_addr;
      dma_wdata = v.dma_wdata; dma_last = v.dma_last;
   endtask

   task automatic wait_dma_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dma_gnt) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   vec_t vecs [0:20];

   initial begin
      vin_t NONE, RST, C_RD10, BOTH, D_ONLY;
      bit   ok;
      int   n, cyc, prev, beat, acks;
      logic exp_dma  [0:8];
      logic [7:0] exp_addr [0:8];

      NONE   = in_v(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      RST    = in_v(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      C_RD10 = in_v(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      BOTH   = in_v(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1);
      D_ONLY = in_v(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1);

      // Row i: inputs driven in cycle i, outputs expected in cycle i.
      vecs[0]  = '{RST,    o_idle()};
      vecs[1]  = '{C_RD10, o_idle()};
      vecs[2]  = '{NONE,   o_acc(0, 0, 8'h10, 8'h00)};
      vecs[3]  = '{NONE,   o_rsp(0, 8'hA5)};
      vecs[4]  = '{NONE,   o_idle()};
      vecs[5]  = '{in_v(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 1), o_idle()};
      vecs[6]  = '{NONE,   o_acc(1, 1, 8'h20, 8'h3C)};
      vecs[7]  = '{in_v(1, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0), o_rsp(1, 8'h00)};
      vecs[8]  = '{NONE,   o_acc(0, 0, 8'h20, 8'h00)};
      vecs[9]  = '{NONE,   o_rsp(0, 8'h3C)};
      vecs[10] = '{RST,    o_idle()};
      vecs[11] = '{BOTH,   o_idle()};
      vecs[12] = '{BOTH,   o_acc(0, 0, 8'h10, 8'h00)};
      vecs[13] = '{BOTH,   o_rsp(0, 8'hA5)};
      vecs[14] = '{BOTH,   o_acc(1, 0, 8'h20, 8'h00)};
      vecs[15] = '{BOTH,   o_rsp(1, 8'h3C)};
      vecs[16] = '{BOTH,   o_acc(0, 0, 8'h10, 8'h00)};
      vecs[17] = '{D_ONLY, o_rsp(0, 8'hA5)};
      vecs[18] = '{NONE,   o_acc(1, 0, 8'h20, 8'h00)};
      vecs[19] = '{NONE,   o_rsp(1, 8'h3C)};
      vecs[20] = '{NONE,   o_idle()};

      apply_in(RST);
      for (int i = 0; i <= 20; i++) begin
         @(posedge clk);
         #1;
         apply_in(vecs[i].vin);
         @(negedge clk);
         $display("vec %0d: outputs %h", i, act);
         check($sformatf("vec%0d", i), 64'(act), 64'(vecs[i].vexp));
      end

      // DMA 8-beat write burst; CPU requests during beat 2 and gets the port after beat 4.
      exp_dma  = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
      exp_addr = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h10, 8'h45, 8'h46, 8'h47, 8'h48};
      @(negedge clk);
      beat = 1;
      apply_in(in_v(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 8'h81, 0));
      n = 0; cyc = 0; prev = 0;
      while (n < 9 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cpu_gnt || dma_gnt) begin
            $display("burst grant %0d: %s addr %h", n, dma_gnt ? "DMA" : "CPU", mem_addr);
            check($sformatf("burst_owner%0d", n), 64'(dma_gnt), 64'(exp_dma[n]));
            check($sformatf("burst_addr%0d", n), 64'(mem_addr), 64'(exp_addr[n]));
            if (n > 0) check($sformatf("burst_gap%0d", n), 64'(cyc - prev), 64'd2);
            prev = cyc;
            if (dma_gnt) begin
               if (beat == 2) begin
                  cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
               end
               beat++;
               if (beat <= 8) begin
                  dma_addr = 8'h40 + 8'(beat);
                  dma_wdata = 8'h80 + 8'(beat);
                  dma_last = (beat == 8);
               end else begin
                  dma_req = 1'b0;
                  dma_last = 1'b0;
               end
            end else begin
               cpu_req = 1'b0;
            end
            n++;
         end
      end
      check("burst_grants", 64'(n), 64'd9);
      @(negedge clk);
      @(negedge clk);
      check("burst_idle_busy", 64'(busy), 64'd0);
      check("burst_ram_last", 64'(ram[8'h48]), 64'h88);

      // Reset asserted during the ACC cycle of a DMA read.
      apply_in(in_v(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1));
      wait_dma_gnt(ok);
      check("rst_dma_gnt_seen", 64'(ok), 64'd1);
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h10;
      @(negedge clk);
      check("rst_mid_acc_zero", 64'(act), 64'(o_idle()));
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cpu_first", 64'(act), 64'(o_acc(0, 0, 8'h10, 8'h00)));
      cpu_req = 1'b0;
      @(negedge clk);
      check("rst_cpu_ack", 64'(act), 64'(o_rsp(0, 8'hA5)));
      @(negedge clk);
      check("rst_dma_acc", 64'(act), 64'(o_acc(1, 0, 8'h20, 8'h00)));
      dma_req = 1'b0;
      @(negedge clk);
      check("rst_dma_ack", 64'(act), 64'(o_rsp(1, 8'h3C)));

      // DMA drops its request during ACC: the beat still completes once.
      @(negedge clk);
      apply_in(in_v(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0));
      wait_dma_gnt(ok);
      check("drop_gnt_seen", 64'(ok), 64'd1);
      dma_req = 1'b0;
      @(negedge clk);
      check("drop_rsp", 64'(act), 64'(o_rsp(1, 8'hA5)));
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dma_ack) acks++;
      end
      check("drop_no_extra_ack", 64'(acks), 64'd0);
      check("drop_idle_busy", 64'(busy), 64'd0);

      check("exclusive_gnt_ack", 64'(excl_viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data RAM between two requesters.
- CPU port: fetch/execute accesses issued by the control unit sequence.
- DMA port: program loader / I/O block; may issue bursts.
- Sits between both requesters and the RAM. It owns the RAM address, data and readwrite lines, sequences every access through a fixed grant/response handshake, and bounds DMA bursts so the CPU is never starved.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- MAX_BURST, 4, maximum consecutive DMA beats while cpu_req is pending (legal range 1..15)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_rw  in  1  1 = write, 0 = read (same sense as the RAM readwrite line)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access is on the RAM this cycle
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid only while cpu_ack=1 on a read
- dma_req, dma_rw, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meaning as the CPU port
- dma_last  in  1  current beat is the final beat of the burst
- dma_gnt, dma_ack, dma_rdata  out  1/1/DATA_W  same meaning as the CPU port
- mem_en  out  1  RAM access strobe
- mem_rw  out  1  RAM readwrite, 1 = write
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM synchronous read data, valid the cycle after mem_en
- busy  out  1  state is not IDLE

Behaviour:
- Reset: when rst_n=0 at a rising edge:
  - state=IDLE, last_owner=DMA (so the CPU wins the first tie), beat_cnt=0, latched request fields=0.
  - All outputs are 0.
  - Reset applies mid-transfer too: any in-flight access is abandoned with no ack.
- States:
  - IDLE: no access in progress.
  - ACC: one cycle. mem_en=1. mem_rw/mem_addr/mem_wdata come from request fields latched on entry. The owner's gnt=1.
  - RSP: one cycle. mem_en=0. The owner's ack=1. On a read, the owner's rdata=mem_rdata; otherwise rdata=0.
- Latency: req high in IDLE at cycle N -> ACC at N+1 -> RSP (ack) at N+2. Minimum 2 cycles per beat.
- Back-to-back: the arbitration decision at the end of RSP can go directly to ACC, with no idle bubble.
- Arbitration: evaluated in IDLE, and in RSP using the request lines for the next beat.
  - Only one requester active: grant it.
  - DMA burst in progress (last beat was DMA, its dma_last=0, beat_cnt<MAX_BURST): DMA keeps the port even if cpu_req=1.
  - Otherwise, with both requesting: grant the requester that is not last_owner (round-robin).
  - No request: go to IDLE.
- beat_cnt:
  - Increments on each DMA ACC, saturating at 15.
  - Clears on any CPU grant, and on a DMA beat completed with dma_last=1.
  - MAX_BURST limits the burst only while cpu_req=1. With cpu_req=0, DMA continues unbounded and beat_cnt saturates.
- last_owner updates on each ACC entry.
- Request fields are latched on the ACC entry edge. Requester changes after that edge do not affect the beat in flight.
- Protocol violations:
  - A requester dropping req during ACC or RSP does not cancel the beat; it completes and ack still pulses.
  - Ack is never asserted on both ports in the same cycle. Same for gnt.
- Outputs are registered, or decoded only from state plus latched fields. There are no combinational paths from any req input to gnt or mem_*.
  - Exception: rdata is a gated passthrough of mem_rdata.

Test Plan:
- Reset then CPU read of addr 0x10 (RAM holds 0xA5): cpu_req at cycle 1 -> cpu_gnt and mem_en with mem_addr=0x10, mem_rw=0 at cycle 2; cpu_ack with cpu_rdata=0xA5 at cycle 3; busy=0 at cycle 4.
- DMA write of 0x3C to 0x20 -> mem_rw=1, mem_wdata=0x3C during ACC; dma_ack the next cycle; subsequent CPU read of 0x20 returns 0x3C.
- cpu_req and dma_req rise together after reset -> CPU served first, then DMA in the next cycle after CPU RSP; with both held continuously, grants alternate C,D,C,D.
- DMA 8-beat burst (dma_last on beat 8), cpu_req asserted during beat 2, MAX_BURST=4 -> DMA beats 1-4, then one CPU beat, then DMA beats 5-8 (beat_cnt restarts); no bubbles between beats.
- rst_n=0 during ACC of a DMA read -> next cycle all outputs 0, no dma_ack; after release, a pending cpu_req is granted first.
- dma_req dropped during ACC -> beat completes, dma_ack pulses once, arbiter returns to IDLE.
